key_switch_io: RTL

- Debounced, memory-mapped input controller for the board KEY and SW pins.
- Sits directly upstream of the processor's data-memory/I/O read path.
- Synchronises and debounces the raw pins, and latches key-press events in a sticky capture register.
- The load path reads it at ADDR_KEY, ADDR_SW and ADDR_KEYCTRL; the store path clears captured events.

---
 rtl/key_switch_io_pkg.sv | 36 +++
 rtl/key_switch_io_if.sv | 33 +++
 rtl/debounce_channel.sv | 72 +++++++
 rtl/key_switch_io.sv | 97 +++++++++
 4 files changed

// File: rtl/key_switch_io_pkg.sv
// Shared constants for the KEY/SW input controller.
// Holds the memory-map addresses, bus width and debounce defaults that the
// processor top, the data-memory block and key_switch_io all reference.
package key_switch_io_pkg;

    localparam int unsigned DBITS                 = 32;
    localparam int unsigned NUM_KEYS              = 4;
    localparam int unsigned NUM_SW                = 10;
    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 500000;
    localparam int unsigned CNT_BITS_50MHZ        = 20;

    localparam logic [DBITS-1:0] ADDR_KEY     = 32'hF000_0010;
    localparam logic [DBITS-1:0] ADDR_SW      = 32'hF000_0014;
    localparam logic [DBITS-1:0] ADDR_KEYCTRL = 32'hF000_0110;

    typedef enum logic [1:0] {
        SelNone,
        SelKey,
        SelSw,
        SelKeyCtrl
    } rd_sel_e;

    // Full-width compare, so no address aliases onto a register.
    function automatic rd_sel_e decode_addr(input logic [DBITS-1:0] a);
        if (a == ADDR_KEY) begin
            return SelKey;
        end else if (a == ADDR_SW) begin
            return SelSw;
        end else if (a == ADDR_KEYCTRL) begin
            return SelKeyCtrl;
        end
        return SelNone;
    endfunction

endpackage

// File: rtl/key_switch_io_if.sv
// Data-memory/I/O bus between the processor load/store path and key_switch_io.
//   addr   : data address from the ALU
//   wrEn   : store strobe, sampled on rising clk
//   wrData : store data
//   rdData : read data, combinational from registered state
//   rdHit  : addr matches one of the mapped registers
// master = processor side, slave = key_switch_io side.
interface key_switch_io_if;
    import key_switch_io_pkg::*;

    logic [DBITS-1:0] addr;
    logic             wrEn;
    logic [DBITS-1:0] wrData;
    logic [DBITS-1:0] rdData;
    logic             rdHit;

    modport master (
        output addr,
        output wrEn,
        output wrData,
        input  rdData,
        input  rdHit
    );

    modport slave (
        input  addr,
        input  wrEn,
        input  wrData,
        output rdData,
        output rdHit
    );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter and stable register.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   raw       : raw asynchronous pin
//   RESET_VAL : value the synchroniser flops take in reset (pin's idle level)
//   stable    : debounced value (INVERT applied after synchronisation)
//   riseEdge  : one-cycle pulse on the edge where stable goes 0->1
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_BITS        = 20,
    parameter bit          INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic RESET_VAL,
    output logic stable,
    output logic riseEdge
);

    localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                sample;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                stable_q, stable_d;
    logic                accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q ^ INVERT;

    // Counter only runs while the synchronised input differs from stable; it
    // clears on any bounce back and on accept, so it can never wrap.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            accept   = 1'b1;
            stable_d = sample;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    // Pulse coincides with the edge that updates stable_q.
    assign riseEdge = accept & sample;

endmodule

// File: rtl/key_switch_io.sv
// Debounced memory-mapped input controller for the board KEY and SW pins.
//   clk      : system clock (PLL c0)
//   reset    : asynchronous active-low reset
//   KEY      : raw push-buttons, active-low
//   SW       : raw slide switches
//   bus      : load/store port (addr, wrEn, wrData, rdData, rdHit)
//   keyState : debounced key state, 1 = pressed
//   keyEvent : sticky press-capture bits, write-1-to-clear at ADDR_KEYCTRL
module key_switch_io
    import key_switch_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int unsigned CNT_BITS        = CNT_BITS_50MHZ
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    key_switch_io_if.slave      bus,
    output logic [NUM_KEYS-1:0] keyState,
    output logic [NUM_KEYS-1:0] keyEvent
);

    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_SW-1:0]   sw_stable;
    logic [NUM_SW-1:0]   unused_sw_rise;
    logic [NUM_KEYS-1:0] key_event_q, key_event_d;
    logic [NUM_KEYS-1:0] clr_mask;
    logic                unused_wr_upper;
    rd_sel_e             rd_sel;

    // Keys idle high; the channel inverts after the synchroniser so 1 = pressed.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .INVERT          (1'b1)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .raw       (KEY[i]),
            .RESET_VAL (1'b1),
            .stable    (keyState[i]),
            .riseEdge  (key_rise[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .INVERT          (1'b0)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .raw       (SW[i]),
            .RESET_VAL (1'b0),
            .stable    (sw_stable[i]),
            .riseEdge  (unused_sw_rise[i])
        );
    end

    assign unused_wr_upper = ^bus.wrData[DBITS-1:NUM_KEYS];

    // Set beats clear so a press landing on a clear write is not lost.
    always_comb begin
        clr_mask = '0;
        if (bus.wrEn && (bus.addr == ADDR_KEYCTRL)) begin
            clr_mask = bus.wrData[NUM_KEYS-1:0];
        end
        key_event_d = key_rise | (key_event_q & ~clr_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_event_q <= '0;
        end else begin
            key_event_q <= key_event_d;
        end
    end

    assign keyEvent = key_event_q;

    assign rd_sel = decode_addr(bus.addr);

    always_comb begin
        bus.rdData = '0;
        bus.rdHit  = 1'b1;
        unique case (rd_sel)
            SelKey:     bus.rdData = {{(DBITS - NUM_KEYS){1'b0}}, keyState};
            SelSw:      bus.rdData = {{(DBITS - NUM_SW){1'b0}}, sw_stable};
            SelKeyCtrl: bus.rdData = {{(DBITS - NUM_KEYS){1'b0}}, key_event_q};
            default:    bus.rdHit  = 1'b0;
        endcase
    end

endmodule
